// File: rtl/key_pulse_gen_pkg.sv
// Shared types and default timing constants for the key pulse generator.
// The defaults are tuned for board-level push buttons on a fast system clock.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_DLY,
    HOLD_RPT
  } key_state_t;

  localparam int DEB_CYC_DEF = 20000;
  localparam int RPT_DLY_DEF = 10000000;
  localparam int RPT_PER_DEF = 2000000;

endpackage

// File: rtl/key_pulse_gen_if.sv
// Raw key/DIP inputs and the conditioned command strobes toward the counter.
// master drives the raw inputs; slave is the conditioner side.
interface key_pulse_gen_if;

  logic       key_up;
  logic       key_dn;
  logic       key_load;
  logic [7:0] dsw;
  logic       up_p;
  logic       dn_p;
  logic       load_p;
  logic [7:0] dout;

  modport master (
    output key_up, key_dn, key_load, dsw,
    input  up_p, dn_p, load_p, dout
  );

  modport slave (
    input  key_up, key_dn, key_load, dsw,
    output up_p, dn_p, load_p, dout
  );

endinterface

// File: rtl/key_pulse_gen_channel.sv
// One key lane: 2-flop synchronizer, debounce counter, press/auto-repeat FSM.
// pulse_o is registered; level_o is the debounced key level.
module key_channel
  import key_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF,
  parameter int RPT_DLY = RPT_DLY_DEF,
  parameter int RPT_PER = RPT_PER_DEF,
  parameter bit RPT_EN  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic key_i,
  input  logic rpt_mask_i,
  output logic pulse_o,
  output logic level_o
);

  localparam int TMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int DW   = $clog2(DEB_CYC);
  localparam int TW   = $clog2(TMAX);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(RPT_DLY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(RPT_PER - 1);

  logic [1:0]    sync_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          level_q, level_d;
  key_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pulse_q, pulse_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q    <= 2'b00;
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
      state_q   <= IDLE;
      timer_q   <= '0;
      pulse_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_i};
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      pulse_q   <= pulse_d;
    end
  end

  // Any cycle where the synchronized key agrees with the accepted level restarts the count.
  always_comb begin
    deb_cnt_d = '0;
    level_d   = level_q;
    if (sync_q[1] != level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        level_d = ~level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Repeat pulses honour rpt_mask_i; the initial press pulse never does.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q) begin
          state_d = HOLD_DLY;
          timer_d = '0;
          pulse_d = 1'b1;
        end
      end
      HOLD_DLY: begin
        if (!level_q) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (RPT_EN) begin
          if (timer_q == DLY_LAST) begin
            state_d = HOLD_RPT;
            timer_d = '0;
            pulse_d = ~rpt_mask_i;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      HOLD_RPT: begin
        if (!level_q) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == PER_LAST) begin
          timer_d = '0;
          pulse_d = ~rpt_mask_i;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign pulse_o = pulse_q;
  assign level_o = level_q;

endmodule

// File: rtl/key_pulse_gen.sv
// Key front end: three conditioned key lanes, UP/DN repeat conflict masking,
// and a plain synchronizer for the DIP-switch load value.
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF,
  parameter int RPT_DLY = RPT_DLY_DEF,
  parameter int RPT_PER = RPT_PER_DEF
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  key_pulse_gen_if.slave bus
);

  logic       up_level;
  logic       dn_level;
  logic       unused_load_level;
  logic       rpt_mask;
  logic [7:0] dsw_meta_q;
  logic [7:0] dsw_q;

  // Holding both directions would make the counter jitter, so repeats pause instead.
  assign rpt_mask = up_level & dn_level;

  key_channel #(
    .DEB_CYC(DEB_CYC), .RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER), .RPT_EN(1'b1)
  ) u_up (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .key_i      (bus.key_up),
    .rpt_mask_i (rpt_mask),
    .pulse_o    (bus.up_p),
    .level_o    (up_level)
  );

  key_channel #(
    .DEB_CYC(DEB_CYC), .RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER), .RPT_EN(1'b1)
  ) u_dn (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .key_i      (bus.key_dn),
    .rpt_mask_i (rpt_mask),
    .pulse_o    (bus.dn_p),
    .level_o    (dn_level)
  );

  key_channel #(
    .DEB_CYC(DEB_CYC), .RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER), .RPT_EN(1'b0)
  ) u_load (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .key_i      (bus.key_load),
    .rpt_mask_i (1'b0),
    .pulse_o    (bus.load_p),
    .level_o    (unused_load_level)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dsw_meta_q <= 8'h00;
      dsw_q      <= 8'h00;
    end else begin
      dsw_meta_q <= bus.dsw;
      dsw_q      <= dsw_meta_q;
    end
  end

  assign bus.dout = dsw_q;

endmodule
